// File: rtl/seg_scan_driver_if.sv
// Display-side bus of the four-digit seven-segment scanner: staged inputs from the host
// and the multiplexed, active-low drive toward the display.
interface seg_scan_driver_if;
    logic [15:0] digits;
    logic        load;
    logic [3:0]  dpMask;
    logic [3:0]  blank;
    logic [3:0]  segEn;
    logic [6:0]  sevSeg;
    logic        segDec;
    logic [1:0]  scanIdx;

    modport master (
        output digits, load, dpMask, blank,
        input  segEn, sevSeg, segDec, scanIdx
    );

    modport slave (
        input  digits, load, dpMask, blank,
        output segEn, sevSeg, segDec, scanIdx
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with staged/shadow display registers.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits 3..1).
module seg_scan_driver #(
    parameter int DIV_MAX = 100000,
    parameter int DEAD    = 16
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_driver_if.slave   bus
);
    localparam int                CNT_W    = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 2;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV_MAX - 1);
    localparam logic [CNT_W-1:0]  CNT_DEAD = CNT_W'(DEAD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       scan_idx_q, scan_idx_d;
    logic             pending_q, pending_d;
    logic [15:0]      stg_digits_q, stg_digits_d;
    logic [3:0]       stg_dp_q, stg_dp_d;
    logic [3:0]       stg_blank_q, stg_blank_d;
    logic [15:0]      shd_digits_q, shd_digits_d;
    logic [3:0]       shd_dp_q, shd_dp_d;
    logic [3:0]       shd_blank_q, shd_blank_d;
    logic [3:0]       seg_en_q, seg_en_d;
    logic [6:0]       sev_seg_q, sev_seg_d;
    logic             seg_dec_q, seg_dec_d;

    logic             tick;
    logic             wrap;
    logic [3:0]       cur_nib;
    logic [3:0]       lz_dark;
    logic             dark;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    always_comb begin
        tick       = (cnt_q == CNT_LAST);
        wrap       = tick && (scan_idx_q == 2'd3);
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        scan_idx_d = tick ? scan_idx_q + 2'd1 : scan_idx_q;
    end

    // Shadow only moves on the 3->0 wrap so a frame never mixes old and new digits;
    // a load coinciding with the wrap bypasses staging and lands directly.
    always_comb begin
        pending_d    = pending_q;
        stg_digits_d = stg_digits_q;
        stg_dp_d     = stg_dp_q;
        stg_blank_d  = stg_blank_q;
        shd_digits_d = shd_digits_q;
        shd_dp_d     = shd_dp_q;
        shd_blank_d  = shd_blank_q;
        if (wrap && bus.load) begin
            shd_digits_d = bus.digits;
            shd_dp_d     = bus.dpMask;
            shd_blank_d  = bus.blank;
            pending_d    = 1'b0;
        end else if (wrap && pending_q) begin
            shd_digits_d = stg_digits_q;
            shd_dp_d     = stg_dp_q;
            shd_blank_d  = stg_blank_q;
            pending_d    = 1'b0;
        end else if (bus.load) begin
            stg_digits_d = bus.digits;
            stg_dp_d     = bus.dpMask;
            stg_blank_d  = bus.blank;
            pending_d    = 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_dark    = 4'b0000;
        lz_dark[3] = (shd_digits_q[15:12] == 4'h0);
        lz_dark[2] = lz_dark[3] && (shd_digits_q[11:8] == 4'h0);
        lz_dark[1] = lz_dark[2] && (shd_digits_q[7:4] == 4'h0);
    end
`else
    always_comb begin
        lz_dark = 4'b0000;
    end
`endif

    always_comb begin
        case (scan_idx_q)
            2'd0:    cur_nib = shd_digits_q[3:0];
            2'd1:    cur_nib = shd_digits_q[7:4];
            2'd2:    cur_nib = shd_digits_q[11:8];
            default: cur_nib = shd_digits_q[15:12];
        endcase
        dark      = shd_blank_q[scan_idx_q] | lz_dark[scan_idx_q];
        sev_seg_d = hex_glyph(cur_nib);
        seg_dec_d = ~shd_dp_q[scan_idx_q];
        // Dead band at the start of each slot hides ghosting while segments settle.
        if ((cnt_q < CNT_DEAD) || dark) begin
            seg_en_d = 4'b1111;
        end else begin
            seg_en_d = ~(4'b0001 << scan_idx_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            scan_idx_q   <= 2'd0;
            pending_q    <= 1'b0;
            stg_digits_q <= 16'h0000;
            stg_dp_q     <= 4'h0;
            stg_blank_q  <= 4'h0;
            shd_digits_q <= 16'h0000;
            shd_dp_q     <= 4'h0;
            shd_blank_q  <= 4'h0;
            seg_en_q     <= 4'hF;
            sev_seg_q    <= 7'h7F;
            seg_dec_q    <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            scan_idx_q   <= scan_idx_d;
            pending_q    <= pending_d;
            stg_digits_q <= stg_digits_d;
            stg_dp_q     <= stg_dp_d;
            stg_blank_q  <= stg_blank_d;
            shd_digits_q <= shd_digits_d;
            shd_dp_q     <= shd_dp_d;
            shd_blank_q  <= shd_blank_d;
            seg_en_q     <= seg_en_d;
            sev_seg_q    <= sev_seg_d;
            seg_dec_q    <= seg_dec_d;
        end
    end

    assign bus.segEn   = seg_en_q;
    assign bus.sevSeg  = sev_seg_q;
    assign bus.segDec  = seg_dec_q;
    assign bus.scanIdx = scan_idx_q;
endmodule
